// File: rtl/cache_types_pkg.sv
// Shared types and default widths for the physical-memory arbiter.
// Combinational definitions only: no latency, no flow control.
// Grant states are one-hot so each grant decodes from a single bit.
package cache_types_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'b001,
        ARB_GNT_I = 3'b010,
        ARB_GNT_D = 3'b100
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } gnt_side_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating event counter for arbiter contention visibility.
// Latency: count reflects an inc one cycle later.
// No backpressure: sticks at all-ones instead of wrapping.
module arb_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between I-side fills and D-side victim traffic; PMEM_ARB_ROUND_ROBIN_EN alternates on contention.
// Latency: grant one cycle after a request is seen in idle; resp passes through combinationally; one idle cycle after each resp.
// Backpressure: the loser holds its request until granted; the winner holds the port until pmem_resp.
module pmem_arbiter
    import cache_types_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  contention_cnt
);

    arb_state_t state, state_nxt;
    gnt_side_t  last_gnt;
    logic       i_req, d_req, both_req, pick_d;

    assign i_req    = i_pmem_read;
    assign d_req    = d_pmem_read | d_pmem_write;
    assign both_req = i_req & d_req;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    assign pick_d = (last_gnt == SIDE_I);
`else
    assign pick_d = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= SIDE_D;
        end else if (state == ARB_IDLE && state_nxt == ARB_GNT_I) begin
            last_gnt <= SIDE_I;
        end else if (state == ARB_IDLE && state_nxt == ARB_GNT_D) begin
            last_gnt <= SIDE_D;
        end
    end

    // Strobes derive from state so an async reset drops them immediately.
    always_comb begin
        state_nxt    = state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = d_pmem_address;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (both_req) begin
                    state_nxt = pick_d ? ARB_GNT_D : ARB_GNT_I;
                end else if (d_req) begin
                    state_nxt = ARB_GNT_D;
                end else if (i_req) begin
                    state_nxt = ARB_GNT_I;
                end
            end
            ARB_GNT_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                if (pmem_resp) begin
                    i_pmem_resp = 1'b1;
                    state_nxt   = ARB_IDLE;
                end
            end
            ARB_GNT_D: begin
                pmem_write = d_pmem_write;
                pmem_read  = d_pmem_read & ~d_pmem_write;
                if (pmem_resp) begin
                    d_pmem_resp = 1'b1;
                    state_nxt   = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign pmem_wdata   = d_pmem_wdata;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    arb_sat_counter #(.CNT_W(CNT_W)) u_contention (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state == ARB_IDLE) & both_req),
        .count (contention_cnt)
    );

    a_last_gnt_tracks_grant: assert property (@(posedge clk) disable iff (!rst_n)
        (state != ARB_IDLE) |-> (last_gnt == ((state == ARB_GNT_D) ? SIDE_D : SIDE_I)));

endmodule
